mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Shares the single off-chip memory port between the I-cache (read-only refills) and the D-cache (refills and write-backs). It sits between the two cache miss interfaces and the memory model, below the fetch and memory pipeline stages. Service is one transaction at a time with round-robin priority, so a streaming fetch loop cannot starve data traffic, and a store-heavy loop cannot starve fetch.

Parameters:
ADDR_W, 28, memory block address width (word address, 16-byte lines)
DATA_W, 128, memory line width in bits

Ports:
clk  in  1  system clock; all state updates on rising edge
rst_n  in  1  reset; synchronous, active-low
i_read  in  1  I-cache refill request; held until i_ready
i_addr  in  ADDR_W  I-cache line address
i_rdata  out  DATA_W  refill data; valid only while i_ready=1
i_ready  out  1  one-cycle completion pulse to I-cache
d_read  in  1  D-cache refill request; held until d_ready
d_write  in  1  D-cache write-back request; held until d_ready
d_addr  in  ADDR_W  D-cache line address
d_wdata  in  DATA_W  write-back data
d_rdata  out  DATA_W  refill data; valid only while d_ready=1
d_ready  out  1  one-cycle completion pulse to D-cache
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data; valid when mem_ready=1
mem_ready  in  1  one-cycle memory completion pulse

Behaviour:
- Clocking and reset: single clock clk. Reset rst_n is synchronous and active-low.
- Reset values: state=IDLE, last_grant=I, all outputs 0, and the address, write-data and read-data registers cleared.
- FSM has four states:
  - IDLE: no request pending -> stay.
  - IDLE: exactly one requester pending -> grant it.
  - IDLE: both pending -> grant the side that is not last_grant. After reset, D wins the first tie.
  - On grant: latch the address (and d_wdata and the op) into registers, update last_grant, go to SERVE_I or SERVE_D.
  - SERVE_I / SERVE_D: drive mem_read or mem_write plus mem_addr and mem_wdata from the registers only, never combinationally from the requester. Wait for mem_ready. On mem_ready: capture mem_rdata into rdata_r and go to RESP.
  - RESP: pulse the granted requester's ready for exactly one cycle. Both mem strobes are 0. Then go to IDLE.
- Data outputs: a single shared rdata_r drives both i_rdata and d_rdata. Its value holds until the next capture. After a write, rdata_r is unchanged.
- Latency: request seen in IDLE at cycle 0 -> mem strobe high in cycles 1..k, where mem_ready arrives in cycle k -> x_ready in cycle k+1 -> IDLE in k+2. Minimum: mem_ready in cycle 1 gives ready in cycle 2.
- Back-to-back: a requester deasserts at the edge ending its ready cycle. The next arbitration uses post-drop request values, so there is no phantom re-grant.
- D op encoding:
  - d_write=1 -> write, regardless of d_read. Both high is a protocol violation; the write is served, and the cache re-issues the read.
  - d_read only -> read.
- Request changes during SERVE are ignored; the latched op and address complete unchanged.
- mem_ready while in IDLE or RESP is ignored, with no state change.
- Mutual exclusion: mem_read and mem_write are never both 1. i_ready and d_ready are never both 1.
- Reset mid-transaction: the next edge returns to IDLE and drops the strobes. The outstanding transaction is abandoned and no ready is issued.

Decomposition:
- Shared package: state encoding (IDLE, SERVE_I, SERVE_D, RESP), grant constants (GNT_I=0, GNT_D=1), and default ADDR_W/DATA_W.
- Single module; no sub-module is warranted. The round-robin pick is a two-line function.

Test Plan:
- Lone I read at addr 0x0000010, memory answers after 3 cycles with 0xA5..A5 -> mem_read high cycles 1–3, mem_addr=0x0000010, i_ready pulses in cycle 4 with i_rdata=0xA5..A5, d_ready stays 0.
- Simultaneous i_read (0x10) and d_read (0x20) right after reset -> D is served first (mem_addr=0x20); I is served next (0x10) with no idle cycle beyond IDLE, and each ready pulses exactly once.
- Continuous d_write stream alongside a held i_read -> grants strictly alternate D, I, D, I, and mem_wdata equals the latched d_wdata each D turn.
- d_addr changed from 0x30 to 0x40 mid-SERVE_D -> mem_addr stays 0x30 until RESP, and the changed address is not re-granted after d_ready.
- rst_n low for one cycle during SERVE_I -> strobes are 0 on the next cycle, no i_ready, state is IDLE, and a later request is served normally.
- Spurious mem_ready in IDLE, plus d_read and d_write both high -> no state change for the spurious pulse; the D request issues mem_write only, then d_ready.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the I/D-cache memory port arbiter.
package mem_arbiter_pkg;

    localparam int DEF_ADDR_W = 28;
    localparam int DEF_DATA_W = 128;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        RESP    = 2'd3
    } arb_state_t;

    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

    // Round-robin pick: on a tie the side that did not win last time goes next.
    function automatic logic rr_pick(input logic i_req, input logic d_req, input logic last);
        if (i_req && d_req) return ~last;
        return d_req ? GNT_D : GNT_I;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between I-cache refills and
// D-cache refills/write-backs, one registered transaction at a time.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    arb_state_t        state, state_nxt;
    logic              last_grant;
    logic              grant_r;
    logic              write_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic [DATA_W-1:0] rdata_r;

    logic              d_req;
    logic              grant_pick;
    logic              grant_en;
    logic              capture_en;

    assign d_req      = d_read || d_write;
    assign grant_pick = rr_pick(i_read, d_req, last_grant);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= GNT_I;
            grant_r    <= GNT_I;
            write_r    <= 1'b0;
            addr_r     <= '0;
            wdata_r    <= '0;
            rdata_r    <= '0;
        end else begin
            state <= state_nxt;
            if (grant_en) begin
                last_grant <= grant_pick;
                grant_r    <= grant_pick;
                // A write wins over a simultaneous read; the cache re-issues the read.
                write_r    <= (grant_pick == GNT_D) && d_write;
                addr_r     <= (grant_pick == GNT_D) ? d_addr : i_addr;
                wdata_r    <= d_wdata;
            end
            if (capture_en) rdata_r <= mem_rdata;
        end
    end

    always_comb begin
        state_nxt  = state;
        grant_en   = 1'b0;
        capture_en = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        i_ready    = 1'b0;
        d_ready    = 1'b0;
        case (state)
            IDLE: begin
                if (i_read || d_req) begin
                    grant_en  = 1'b1;
                    state_nxt = (grant_pick == GNT_D) ? SERVE_D : SERVE_I;
                end
            end
            SERVE_I, SERVE_D: begin
                mem_read  = !write_r;
                mem_write = write_r;
                if (mem_ready) begin
                    capture_en = !write_r;
                    state_nxt  = RESP;
                end
            end
            RESP: begin
                i_ready   = (grant_r == GNT_I);
                d_ready   = (grant_r == GNT_D);
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign mem_addr  = addr_r;
    assign mem_wdata = wdata_r;
    assign i_rdata   = rdata_r;
    assign d_rdata   = rdata_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized bench for mem_arbiter against a transaction-level model.
module tb_mem_arbiter;

    localparam int AW = 28;
    localparam int DW = 128;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_read, d_read, d_write, mem_ready;
    logic [AW-1:0] i_addr, d_addr;
    logic [DW-1:0] d_wdata, mem_rdata;
    logic [DW-1:0] i_rdata, d_rdata, mem_wdata;
    logic          i_ready, d_ready, mem_read, mem_write;
    logic [AW-1:0] mem_addr;

    int checks = 0;
    int errors = 0;

    // Model: what transaction is in flight. phase 0 = none, 1 = memory access
    // outstanding, 2 = completion being reported to the requester.
    int            m_phase = 0;
    bit            m_side_d = 1'b0;
    bit            m_write = 1'b0;
    bit            m_last_d = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0;
    logic [DW-1:0] m_rdata = '0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    function automatic logic [DW-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("mem_read", 128'(mem_read), 128'(m_phase == 1 && !m_write));
        chk("mem_write", 128'(mem_write), 128'(m_phase == 1 && m_write));
        chk("i_ready", 128'(i_ready), 128'(m_phase == 2 && !m_side_d));
        chk("d_ready", 128'(d_ready), 128'(m_phase == 2 && m_side_d));
        chk("i_rdata", i_rdata, m_rdata);
        chk("d_rdata", d_rdata, m_rdata);
        if (m_phase == 1) chk("mem_addr", 128'(mem_addr), 128'(m_addr));
        if (m_phase == 1 && m_write) chk("mem_wdata", mem_wdata, m_wdata);
    endtask

    // Advance one clock: predict from the inputs held before the edge, then check.
    task automatic step();
        int            np  = m_phase;
        bit            ns  = m_side_d;
        bit            nw  = m_write;
        bit            nl  = m_last_d;
        logic [AW-1:0] na  = m_addr;
        logic [DW-1:0] nwd = m_wdata;
        logic [DW-1:0] nrd = m_rdata;
        bit            dreq = d_read || d_write;
        if (!rst_n) begin
            np = 0; nl = 1'b0; nw = 1'b0; nrd = '0;
        end else if (m_phase == 0) begin
            if (i_read || dreq) begin
                ns  = (i_read && dreq) ? !m_last_d : dreq;
                nl  = ns;
                nw  = ns && d_write;
                na  = ns ? d_addr : i_addr;
                nwd = d_wdata;
                np  = 1;
            end
        end else if (m_phase == 1) begin
            if (mem_ready) begin
                if (!m_write) nrd = mem_rdata;
                np = 2;
            end
        end else begin
            np = 0;
        end
        @(posedge clk);
        #1;
        m_phase = np; m_side_d = ns; m_write = nw; m_last_d = nl;
        m_addr = na; m_wdata = nwd; m_rdata = nrd;
        check_outputs();
    endtask

    // From an idle cycle with a request raised: mem_ready arrives in service cycle lat.
    task automatic serve(input int lat, input logic [DW-1:0] data);
        step();
        for (int j = 1; j < lat; j++) step();
        mem_ready = 1'b1;
        mem_rdata = data;
        step();
        mem_ready = 1'b0;
        mem_rdata = rand_line();
    endtask

    logic [DW-1:0] saved;
    int i_issued, d_issued, i_done, d_done, lat_cnt;

    initial begin
        rst_n = 1'b0; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; mem_ready = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;

        // Reset values
        step(); step();
        chk("rst_mem_read", 128'(mem_read), '0);
        chk("rst_mem_addr", 128'(mem_addr), '0);
        chk("rst_mem_wdata", mem_wdata, '0);
        chk("rst_rdata", i_rdata, '0);
        rst_n = 1'b1;
        step();

        // Lone I read, memory answers in cycle 3
        i_read = 1'b1; i_addr = 28'h0000010;
        step();
        chk("t1_addr", 128'(mem_addr), 128'h10);
        step(); step();
        mem_ready = 1'b1; mem_rdata = {16{8'hA5}};
        step();
        mem_ready = 1'b0;
        chk("t1_i_ready", 128'(i_ready), 128'd1);
        chk("t1_i_rdata", i_rdata, {16{8'hA5}});
        chk("t1_d_ready", 128'(d_ready), '0);
        i_read = 1'b0;
        step();

        // Tie right after reset: D first, then I
        rst_n = 1'b0; step(); rst_n = 1'b1;
        i_read = 1'b1; i_addr = 28'h10; d_read = 1'b1; d_addr = 28'h20;
        step();
        chk("t2_first_addr", 128'(mem_addr), 128'h20);
        mem_ready = 1'b1; mem_rdata = rand_line(); saved = mem_rdata;
        step();
        mem_ready = 1'b0;
        chk("t2_d_ready", 128'(d_ready), 128'd1);
        chk("t2_d_rdata", d_rdata, saved);
        d_read = 1'b0;
        step();
        step();
        chk("t2_second_addr", 128'(mem_addr), 128'h10);
        mem_ready = 1'b1; mem_rdata = rand_line();
        step();
        mem_ready = 1'b0;
        chk("t2_i_ready", 128'(i_ready), 128'd1);
        i_read = 1'b0;
        step();

        // Held write stream against held fetch: strict alternation
        i_read = 1'b1; i_addr = AW'($urandom);
        d_write = 1'b1; d_addr = AW'($urandom); d_wdata = rand_line();
        for (int g = 0; g < 4; g++) begin
            serve($urandom_range(1, 3), rand_line());
            chk("t3_order", 128'(d_ready), 128'(g % 2 == 0));
            if (d_ready) begin
                d_addr = AW'($urandom); d_wdata = rand_line();
            end else begin
                i_addr = AW'($urandom);
            end
            step();
        end
        i_read = 1'b0; d_write = 1'b0;
        step();

        // Address change during D service is ignored
        d_read = 1'b1; d_addr = 28'h30;
        step();
        d_addr = 28'h40;
        step();
        chk("t4_addr_hold", 128'(mem_addr), 128'h30);
        mem_ready = 1'b1; mem_rdata = rand_line();
        step();
        mem_ready = 1'b0;
        chk("t4_d_ready", 128'(d_ready), 128'd1);
        d_read = 1'b0;
        step(); step();
        chk("t4_no_regrant", 128'(mem_read), '0);

        // Reset during I service abandons it
        i_read = 1'b1; i_addr = 28'h60;
        step(); step();
        rst_n = 1'b0;
        step();
        chk("t5_strobe", 128'(mem_read | mem_write), '0);
        chk("t5_no_ready", 128'(i_ready), '0);
        rst_n = 1'b1;
        saved = rand_line();
        serve(2, saved);
        chk("t5_i_ready", 128'(i_ready), 128'd1);
        chk("t5_i_rdata", i_rdata, saved);
        i_read = 1'b0;
        step();

        // Spurious mem_ready in idle; read+write served as a write only
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        chk("t6_spurious", 128'(mem_read | mem_write), '0);
        d_read = 1'b1; d_write = 1'b1; d_addr = 28'h50; d_wdata = rand_line();
        step();
        chk("t6_write_only", 128'({mem_read, mem_write}), 128'b01);
        chk("t6_wdata", mem_wdata, d_wdata);
        mem_ready = 1'b1; mem_rdata = rand_line();
        step();
        mem_ready = 1'b0;
        chk("t6_d_ready", 128'(d_ready), 128'd1);
        chk("t6_rdata_kept", d_rdata, saved);
        d_read = 1'b0; d_write = 1'b0;
        step();

        // Randomized traffic with random memory latency
        i_issued = 0; d_issued = 0; i_done = 0; d_done = 0; lat_cnt = 0;
        for (int c = 0; c < 6000; c++) begin
            if (i_ready) begin
                i_read = 1'b0; i_done++;
            end else if (!i_read && i_issued < 60 && $urandom_range(0, 3) == 0) begin
                i_read = 1'b1; i_addr = AW'($urandom); i_issued++;
            end
            if (d_ready) begin
                d_read = 1'b0; d_write = 1'b0; d_done++;
            end else if (!d_read && !d_write && d_issued < 60 && $urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 2))
                    0:       begin d_read = 1'b1; d_write = 1'b0; end
                    1:       begin d_read = 1'b0; d_write = 1'b1; end
                    default: begin d_read = 1'b1; d_write = 1'b1; end
                endcase
                d_addr = AW'($urandom); d_wdata = rand_line(); d_issued++;
            end
            if (mem_read || mem_write) begin
                if (lat_cnt == 0) lat_cnt = $urandom_range(1, 4);
                mem_ready = (lat_cnt == 1);
                lat_cnt--;
            end else begin
                lat_cnt = 0;
                mem_ready = ($urandom_range(0, 15) == 0);
            end
            mem_rdata = rand_line();
            if (i_done + d_done == 120) break;
            step();
        end
        chk("rand_drain", 128'(i_done + d_done), 128'd120);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
